// File: rtl/step_sequencer.sv
// Step sequencer: produces the Tstep count and instruction register for the
// control unit, starts on a rising edge of Run, stops at a Clear with Run low,
// and counts retired instructions on Done.
// Optional feature: define STEP_WATCHDOG_EN to add a watchdog that aborts the
// sequencer (sticky StepErr) when Tstep sits at MAX_STEP for WD_LIMIT cycles.
module step_sequencer #(
    parameter int unsigned STEP_W   = 3,
    parameter int unsigned MAX_STEP = 6,
    parameter int unsigned IR_W     = 10,
`ifdef STEP_WATCHDOG_EN
    parameter int unsigned WD_LIMIT = 4,
`endif
    parameter int unsigned CNT_W    = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic              Clear,
    input  logic              Done,
    input  logic              IRin,
    input  logic [IR_W-1:0]   DIN,
    output logic [STEP_W-1:0] Tstep,
    output logic [IR_W-1:0]   Instrucao,
    output logic              Busy,
    output logic [CNT_W-1:0]  InstrCount,
    output logic              StepErr
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    localparam logic [STEP_W-1:0] MaxStep = STEP_W'(MAX_STEP);

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  tstep_q, tstep_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q;
    logic               start;
    logic               start_ok;

`ifdef STEP_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WdLast = WD_W'(WD_LIMIT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    assign start_ok = ~err_q;
    assign StepErr  = err_q;
`else
    assign start_ok = 1'b1;
    assign StepErr  = 1'b0;
`endif

    // Rising edge of Run is the only thing that can start the sequencer
    assign start = Run & ~run_q;

    // Next-state: step counter, IR load, retire count and optional watchdog
    always_comb begin
        state_d = state_q;
        tstep_d = tstep_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
`ifdef STEP_WATCHDOG_EN
        wd_d    = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                tstep_d = '0;
                if (start && start_ok) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (Clear) begin
                    tstep_d = '0;
                    // Stopping is only allowed at an instruction boundary
                    if (!Run) begin
                        state_d = StIdle;
                    end
                end else if (tstep_q < MaxStep) begin
                    tstep_d = tstep_q + 1'b1;
                end
                if (Done) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (IRin) begin
                    ir_d = DIN;
                end
`ifdef STEP_WATCHDOG_EN
                if (!Clear && tstep_q == MaxStep) begin
                    if (wd_q == WdLast) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                        tstep_d = '0;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers, asynchronously cleared by Resetn
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            tstep_q <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
`ifdef STEP_WATCHDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            run_q   <= Run;
`ifdef STEP_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign Tstep      = tstep_q;
    assign Instrucao  = ir_q;
    assign InstrCount = cnt_q;
    assign Busy       = (state_q == StActive);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: inputs change just after the falling edge,
// outputs are checked at the following falling edge.
module tb_step_sequencer;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic        Clear;
    logic        Done;
    logic        IRin;
    logic [9:0]  DIN;
    logic [2:0]  Tstep;
    logic [9:0]  Instrucao;
    logic        Busy;
    logic [15:0] InstrCount;
    logic        StepErr;

    int vectors;
    int miscompares;

    step_sequencer dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Run        (Run),
        .Clear      (Clear),
        .Done       (Done),
        .IRin       (IRin),
        .DIN        (DIN),
        .Tstep      (Tstep),
        .Instrucao  (Instrucao),
        .Busy       (Busy),
        .InstrCount (InstrCount),
        .StepErr    (StepErr)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Run = 1'b0; Clear = 1'b0; Done = 1'b0; IRin = 1'b0; DIN = '0;
        @(negedge Clock);
        vectors++;
        if ({Busy, Tstep, StepErr} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%b tstep=%0d err=%b, want 0 0 0",
                     Busy, Tstep, StepErr);
        end
        vectors++;
        if ({Instrucao, InstrCount} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_data: got ir=%h cnt=%0d, want 0 0", Instrucao, InstrCount);
        end
        Resetn = 1'b1;
        tick();
        vectors++;
        if ({Busy, Tstep} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_no_run: got busy=%b tstep=%0d, want 0 0", Busy, Tstep);
        end
    endtask

    // Start, count T0..T2, load IR at T2
    task automatic test_start();
        Run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({Busy, Tstep} !== {1'b1, 3'(i)}) begin
                miscompares++;
                $display("FAIL start_step%0d: got busy=%b tstep=%0d, want 1 %0d",
                         i, Busy, Tstep, i);
            end
        end
    endtask

    task automatic test_ir_load();
        IRin = 1'b1;
        DIN  = 10'b0011_001_010;
        tick();
        IRin = 1'b0;
        DIN  = '0;
        vectors++;
        if ({Instrucao, Tstep} !== {10'h0CA, 3'd3}) begin
            miscompares++;
            $display("FAIL ir_load: got ir=%h tstep=%0d, want 0ca 3", Instrucao, Tstep);
        end
    endtask

    task automatic test_clear_done();
        Clear = 1'b1;
        Done  = 1'b1;
        tick();
        Clear = 1'b0;
        Done  = 1'b0;
        vectors++;
        if ({Busy, Tstep, InstrCount} !== {1'b1, 3'd0, 16'd1}) begin
            miscompares++;
            $display("FAIL clear_done: got busy=%b tstep=%0d cnt=%0d, want 1 0 1",
                     Busy, Tstep, InstrCount);
        end
    endtask

    // Run falls at T4, stop happens only at the Clear in T5; IDLE ignores inputs
    task automatic test_stop();
        repeat (4) tick();
        vectors++;
        if (Tstep !== 3'd4) begin
            miscompares++;
            $display("FAIL stop_t4: got tstep=%0d, want 4", Tstep);
        end
        Run = 1'b0;
        tick();
        vectors++;
        if ({Busy, Tstep} !== {1'b1, 3'd5}) begin
            miscompares++;
            $display("FAIL run_fall_mid: got busy=%b tstep=%0d, want 1 5", Busy, Tstep);
        end
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        vectors++;
        if ({Busy, Tstep} !== 4'b0) begin
            miscompares++;
            $display("FAIL stop_clear: got busy=%b tstep=%0d, want 0 0", Busy, Tstep);
        end
        IRin = 1'b1; DIN = 10'h3FF; Done = 1'b1; Clear = 1'b1;
        repeat (2) tick();
        IRin = 1'b0; DIN = '0; Done = 1'b0; Clear = 1'b0;
        vectors++;
        if ({Instrucao, InstrCount} !== {10'h0CA, 16'd1}) begin
            miscompares++;
            $display("FAIL idle_ignore: got ir=%h cnt=%0d, want 0ca 1", Instrucao, InstrCount);
        end
        vectors++;
        if ({Busy, Tstep} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_hold: got busy=%b tstep=%0d, want 0 0", Busy, Tstep);
        end
    endtask

    // A second Run edge inside an instruction must not restart the count
    task automatic test_restart_ignored();
        Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        Run = 1'b1;
        tick();
        vectors++;
        if ({Busy, Tstep} !== {1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL restart_ignored: got busy=%b tstep=%0d, want 1 2", Busy, Tstep);
        end
        Run   = 1'b0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        tick();
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_stop: got busy=%b, want 0", Busy);
        end
    endtask

    task automatic test_saturate();
        Run = 1'b1;
        repeat (7) tick();
        vectors++;
        if ({Busy, Tstep} !== {1'b1, 3'd6}) begin
            miscompares++;
            $display("FAIL sat_reach: got busy=%b tstep=%0d, want 1 6", Busy, Tstep);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if ({Busy, Tstep, StepErr} !== {1'b1, 3'd6, 1'b0}) begin
                miscompares++;
                $display("FAIL sat_hold%0d: got busy=%b tstep=%0d err=%b, want 1 6 0",
                         i, Busy, Tstep, StepErr);
            end
        end
        tick();
`ifdef STEP_WATCHDOG_EN
        vectors++;
        if ({Busy, Tstep, StepErr} !== {1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL watchdog_trip: got busy=%b tstep=%0d err=%b, want 0 0 1",
                     Busy, Tstep, StepErr);
        end
        Run = 1'b0;
        tick();
        Run = 1'b1;
        tick();
        vectors++;
        if ({Busy, StepErr} !== 2'b01) begin
            miscompares++;
            $display("FAIL watchdog_lock: got busy=%b err=%b, want 0 1", Busy, StepErr);
        end
`else
        vectors++;
        if ({Busy, Tstep, StepErr} !== {1'b1, 3'd6, 1'b0}) begin
            miscompares++;
            $display("FAIL sat_hold4: got busy=%b tstep=%0d err=%b, want 1 6 0",
                     Busy, Tstep, StepErr);
        end
`endif
    endtask

    // Reach T4 with five retired instructions, then reset between edges
    task automatic test_async_reset();
        Resetn = 1'b0;
        Run    = 1'b0;
        tick();
        Resetn = 1'b1;
        tick();
        Run = 1'b1;
        tick();
        Done = 1'b1;
        tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (3) tick();
        Done = 1'b0;
        tick();
        vectors++;
        if ({Busy, Tstep, InstrCount} !== {1'b1, 3'd4, 16'd5}) begin
            miscompares++;
            $display("FAIL pre_reset: got busy=%b tstep=%0d cnt=%0d, want 1 4 5",
                     Busy, Tstep, InstrCount);
        end
        #2 Resetn = 1'b0;
        #1;
        vectors++;
        if ({Busy, Tstep, InstrCount, Instrucao, StepErr} !== 31'd0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b tstep=%0d cnt=%0d ir=%h err=%b, want all 0",
                     Busy, Tstep, InstrCount, Instrucao, StepErr);
        end
        Run = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({Busy, Tstep} !== 4'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got busy=%b tstep=%0d, want 0 0", Busy, Tstep);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_start();
        test_ir_load();
        test_clear_done();
        test_stop();
        test_restart_ignored();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
